// File: rtl/fir_sched_pkg.sv
// Shared types, default coefficients and width helpers for the multi-channel FIR scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int DEFAULT_COEF [4] = '{1, 2, 3, 4};

    // Taps beyond the fourth continue the 1,2,3,... ramp.
    function automatic int default_coef(input int k);
        return (k < 4) ? DEFAULT_COEF[k[1:0]] : k + 1;
    endfunction

    function automatic int acc_w(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins, wrapping around.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]          req_i,
    input  logic [idx_w(NCH)-1:0]   ptr_i,
    output logic [NCH-1:0]          grant_o,
    output logic [idx_w(NCH)-1:0]   idx_o,
    output logic                    valid_o
);

    localparam int PW = idx_w(NCH);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = ptr_i + PW'(i);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// One shared sequential MAC engine serving NCH channels, each with its own delay line.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int OW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*DW-1:0]       in_data,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    output logic [OW-1:0]           out_data,
    output logic [idx_w(NCH)-1:0]   out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    cfg_we,
    input  logic [idx_w(TAPS)-1:0]  cfg_addr,
    input  logic [DW-1:0]           cfg_data,
    output logic                    cfg_busy
);

    localparam int PW    = idx_w(NCH);
    localparam int KW    = idx_w(TAPS);
    localparam int ACC_W = acc_w(DW, TAPS);

    state_e             state_q, state_d;
    logic [DW-1:0]      dl_q   [NCH][TAPS];
    logic [DW-1:0]      coef_q [TAPS];
    logic [ACC_W-1:0]   acc_q;
    logic [KW-1:0]      k_q;
    logic [PW-1:0]      g_q;
    logic [PW-1:0]      rr_q;
    logic               out_valid_q;
    logic [OW-1:0]      out_data_q;
    logic [PW-1:0]      out_ch_q;

    logic [NCH-1:0]     arb_grant;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;
    logic               accept;
    logic [DW-1:0]      sample;
    logic [2*DW-1:0]    prod;
    logic [OW-1:0]      sat;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req_i   (in_valid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    // A coefficient write in IDLE takes the cycle; arbitration waits.
    assign accept    = (state_q == IDLE) && !cfg_we && arb_any;
    assign in_ready  = accept ? arb_grant : '0;
    assign sample    = in_data[arb_idx*DW +: DW];
    assign prod      = coef_q[k_q] * dl_q[g_q][k_q];
    assign sat       = (|acc_q[ACC_W-1:OW]) ? '1 : acc_q[OW-1:0];
    assign cfg_busy  = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (k_q == KW'(TAPS - 1)) state_d = OUT;
            OUT:     if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            g_q         <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            // NOTE: delay lines and coefficients are register arrays with a defined reset value, not RAM.
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    dl_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= DW'(default_coef(k));
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        coef_q[cfg_addr] <= cfg_data;
                    end else if (accept) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            dl_q[arb_idx][k] <= dl_q[arb_idx][k-1];
                        end
                        dl_q[arb_idx][0] <= sample;
                        acc_q <= '0;
                        k_q   <= '0;
                        g_q   <= arb_idx;
                        rr_q  <= arb_idx + 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    k_q   <= k_q + 1'b1;
                end
                OUT: begin
                    // First OUT cycle registers the saturated result; it then holds until the sink takes it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= sat;
                        out_ch_q    <= g_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
